tt_adder8: RTL and testbench



---
 rtl/adder_pkg.sv | 5 +
 rtl/full_adder.sv | 14 +
 rtl/tt_adder8.sv | 56 +++++
 tb/tb_tt_adder8.sv | 137 +++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants for the TinyTapeout 8-bit registered adder tile.
package adder_pkg;
    localparam int         WIDTH   = 8;
    localparam logic [7:0] SUM_RST = 8'h00;
endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the top chains WIDTH of these into a ripple-carry adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic half_sum;

    assign half_sum = a ^ b;
    assign s        = half_sum ^ cin;
    assign cout     = (a & b) | (cin & half_sum);
endmodule

// File: rtl/tt_adder8.sv
// TinyTapeout user tile: registered 8-bit ripple-carry adder, A on ui_in, B on uio_in.
// rst_n is an active-high synchronous clear despite its name (fixed by the tile wrapper).
module tt_adder8
    import adder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] ui_in,
    input  logic [WIDTH-1:0] uio_in,
    output logic [WIDTH-1:0] uo_out,
    output logic [WIDTH-1:0] uio_out,
    output logic [WIDTH-1:0] uio_oe
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             unused_carry_out;

    assign carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ripple
            full_adder u_fa (
                .a    (ui_in[gi]),
                .b    (uio_in[gi]),
                .cin  (carry[gi]),
                .s    (sum_comb[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    // Final carry is dropped: the tile computes modulo 2**WIDTH.
    assign unused_carry_out = carry[WIDTH];

    always_comb begin
        sum_d = sum_q;
        if (ena) begin
            sum_d = sum_comb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            sum_q <= SUM_RST;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign uo_out  = sum_q;
    assign uio_out = '0;
    assign uio_oe  = '0;
endmodule

// File: tb/tb_tt_adder8.sv
// Scoreboard bench for tt_adder8: the driver queues the expected sum per edge,
// a negedge monitor pops and compares against the registered output.
module tb_tt_adder8;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t       sb_q[$];
    int         n_tests  = 0;
    int         n_failed = 0;
    logic [7:0] model_sum = 8'h00;
    bit         stim_done = 1'b0;

    tt_adder8 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got %02h, expected %02h", name, act, exp);
        end else begin
            $display("[TB] ok   %s: %02h", name, act);
        end
    endtask

    // One clock of stimulus. Reference: reset clears, enable loads (A+B) mod 256, else hold.
    task automatic step(input bit r, input bit e, input logic [7:0] a, input logic [7:0] b,
                        input string name);
        int full;
        @(negedge clk);
        rst_n  = r;
        ena    = e;
        ui_in  = a;
        uio_in = b;
        #1;
        check({name, "/pre-edge"}, uo_out, model_sum);
        @(posedge clk);
        full = int'(a) + int'(b);
        if (r)      model_sum = 8'h00;
        else if (e) model_sum = 8'(full % 256);
        sb_q.push_back('{exp: model_sum, name: name});
    endtask

    // Monitor: output is valid every cycle; compare whatever the scoreboard holds.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t item;
            item = sb_q.pop_front();
            check(item.name, uo_out, item.exp);
            check({item.name, "/uio_out"}, uio_out, 8'h00);
            check({item.name, "/uio_oe"}, uio_oe, 8'h00);
        end
    end

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        int         wait_cycles;
        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h12;
        uio_in = 8'h34;

        step(1, 1, 8'h12, 8'h34, "reset0");
        step(1, 1, 8'h12, 8'h34, "reset1");

        step(0, 1, 8'h12, 8'h34, "basic_12_34");

        step(0, 1, 8'hFF, 8'h01, "wrap_FF_01");
        step(0, 1, 8'h80, 8'h80, "wrap_80_80");
        step(0, 1, 8'hFF, 8'hFF, "wrap_FF_FF");

        step(0, 1, 8'h05, 8'h03, "load_05_03");
        for (int i = 0; i < 3; i++) step(0, 0, 8'h10, 8'h20, $sformatf("hold%0d", i));
        step(0, 1, 8'h10, 8'h20, "reenable_10_20");

        step(0, 1, 8'h01, 8'h01, "b2b_1");
        step(0, 1, 8'h02, 8'h02, "b2b_2");
        step(0, 1, 8'h03, 8'h03, "b2b_3");
        step(0, 1, 8'h7F, 8'h01, "b2b_7F");

        step(1, 1, 8'h22, 8'h11, "midreset");
        step(0, 1, 8'h22, 8'h11, "resume");
        step(1, 0, 8'h22, 8'h11, "reset_noena");
        step(0, 0, 8'h22, 8'h11, "idle_after_reset");

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            step(0, 1, ra, rb, $sformatf("rand%0d_%02h_%02h", i, ra, rb));
        end

        wait_cycles = 0;
        while (sb_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        @(posedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_failed++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        stim_done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

    initial begin
        #200000;
        if (!stim_done) begin
            $display("[TB] FAIL timeout: simulation did not complete, expected finish");
            $fatal(1, "timeout");
        end
    end
endmodule
